// File: rtl/sc_pe_scheduler.sv
// F/G operation sequencer for an SC polar decoder: walks the SC tree and issues PE-array ops and leaf handshakes.
// Optional SCHED_PERF_EN adds busy-cycle and stall-cycle counters (cycle_cnt, stall_cnt).
module sc_pe_scheduler #(
    parameter int LOG_N = 10,
    parameter int LOG_P = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             op_f,
    output logic [3:0]       op_stage,
    output logic [LOG_N-1:0] op_pass,
    output logic             op_last,
    output logic             leaf_valid,
    output logic [LOG_N-1:0] leaf_idx,
    input  logic             leaf_ack
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, LEAF, FIN} state_t;

    localparam logic [3:0]       TOP_STAGE = 4'(LOG_N - 1);
    localparam logic [3:0]       P_STAGE   = 4'(LOG_P);
    localparam logic [LOG_N-1:0] ONE       = LOG_N'(1);
    localparam logic [LOG_N-1:0] LAST_IDX  = '1;

    state_t           state, state_nx;
    logic             op_f_nx;
    logic [3:0]       stage_nx;
    logic [LOG_N-1:0] pass_nx;
    logic [LOG_N-1:0] idx_nx;
    logic [LOG_N-1:0] idx_inc;
    logic [LOG_N-1:0] last_pass;
    logic [3:0]       ctz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_f     <= 1'b0;
            op_stage <= '0;
            op_pass  <= '0;
            leaf_idx <= '0;
        end else begin
            state    <= state_nx;
            op_f     <= op_f_nx;
            op_stage <= stage_nx;
            op_pass  <= pass_nx;
            leaf_idx <= idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        op_f_nx    = op_f;
        stage_nx   = op_stage;
        pass_nx    = op_pass;
        idx_nx     = leaf_idx;
        busy       = (state == CALC) || (state == LEAF);
        done       = (state == FIN);
        op_valid   = (state == CALC);
        leaf_valid = (state == LEAF);

        // Stages below LOG_P fit the PE array in one pass; above, 2^(s-LOG_P) passes.
        last_pass = (op_stage >= P_STAGE) ? (ONE << (op_stage - P_STAGE)) - ONE : '0;
        op_last   = op_valid && (op_pass == last_pass);

        // The next leaf's subtree root sits at the lowest set bit of its index.
        idx_inc = leaf_idx + ONE;
        ctz     = '0;
        for (int unsigned i = LOG_N; i > 0; i--) begin
            if (idx_inc[i-1]) ctz = 4'(i - 1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CALC;
                    idx_nx   = '0;
                    stage_nx = TOP_STAGE;
                    op_f_nx  = 1'b1;
                    pass_nx  = '0;
                end
            end
            CALC: begin
                if (op_ready) begin
                    if (!op_last) begin
                        pass_nx = op_pass + ONE;
                    end else if (op_stage != '0) begin
                        stage_nx = op_stage - 4'd1;
                        op_f_nx  = 1'b1;
                        pass_nx  = '0;
                    end else begin
                        state_nx = LEAF;
                    end
                end
            end
            LEAF: begin
                if (leaf_ack) begin
                    if (leaf_idx == LAST_IDX) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = CALC;
                        idx_nx   = idx_inc;
                        stage_nx = ctz;
                        op_f_nx  = 1'b0;
                        pass_nx  = '0;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef SCHED_PERF_EN
    // Counters only advance while busy, so they stay frozen from done until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if (busy) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
            if (((op_valid && !op_ready) || (leaf_valid && !leaf_ack)) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
